// File: rtl/data_cache_pkg.sv
// Shared types for the direct-mapped write-back data cache: geometry defaults,
// line type and controller state encoding.
package cache_types;

    localparam int S_OFFSET_DEF = 5;
    localparam int S_INDEX_DEF  = 3;
    localparam int S_TAG_DEF    = 32 - S_OFFSET_DEF - S_INDEX_DEF;
    localparam int S_LINE_DEF   = 8 * (2 ** S_OFFSET_DEF);

    typedef logic [S_LINE_DEF-1:0] line_t;

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        ALLOCATE
    } state_t;

endpackage

// File: rtl/data_cache_if.sv
// CPU-side request/response bus between the datapath memory port and the cache.
interface data_cache_if;

    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/data_cache_array.sv
// Flip-flop storage array: asynchronous read, synchronous load, synchronous clear.
module cache_array #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (load) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache; hits answer in the request
// cycle, misses optionally write back the victim and then fill over the line port.
module data_cache
    import cache_types::*;
#(
    parameter int S_OFFSET = S_OFFSET_DEF,
    parameter int S_INDEX  = S_INDEX_DEF,
    localparam int S_TAG   = 32 - S_OFFSET - S_INDEX,
    localparam int S_LINE  = 8 * (2 ** S_OFFSET)
) (
    input  logic              clk,
    input  logic              rst,
    data_cache_if.slave       cpu,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [S_LINE-1:0] pmem_wdata,
    input  logic [S_LINE-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    state_t state, state_next;

    logic [S_TAG-1:0]    tag_in, tag_q;
    logic [S_INDEX-1:0]  index;
    logic [S_OFFSET-3:0] offset;
    logic [S_LINE-1:0]   line_q, data_din;
    logic                valid_q, dirty_q, dirty_din;
    logic                data_ld, tag_ld, valid_ld, dirty_ld;
    logic                req, hit;

    assign tag_in = cpu.mem_address[31 -: S_TAG];
    assign index  = cpu.mem_address[S_OFFSET +: S_INDEX];
    assign offset = cpu.mem_address[S_OFFSET-1:2];
    assign req    = cpu.mem_read | cpu.mem_write;
    assign hit    = valid_q && (tag_q == tag_in);

    cache_array #(.WIDTH(S_LINE), .DEPTH(2 ** S_INDEX)) u_data (
        .clk, .rst, .load(data_ld), .addr(index), .din(data_din), .dout(line_q)
    );
    cache_array #(.WIDTH(S_TAG), .DEPTH(2 ** S_INDEX)) u_tag (
        .clk, .rst, .load(tag_ld), .addr(index), .din(tag_in), .dout(tag_q)
    );
    cache_array #(.WIDTH(1), .DEPTH(2 ** S_INDEX)) u_valid (
        .clk, .rst, .load(valid_ld), .addr(index), .din(1'b1), .dout(valid_q)
    );
    cache_array #(.WIDTH(1), .DEPTH(2 ** S_INDEX)) u_dirty (
        .clk, .rst, .load(dirty_ld), .addr(index), .din(dirty_din), .dout(dirty_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= CHECK;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        cpu.mem_resp  = 1'b0;
        cpu.mem_rdata = '0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_address  = '0;
        pmem_wdata    = '0;
        data_ld       = 1'b0;
        data_din      = line_q;
        tag_ld        = 1'b0;
        valid_ld      = 1'b0;
        dirty_ld      = 1'b0;
        dirty_din     = 1'b0;
        case (state)
            CHECK: begin
                if (req) begin
                    if (hit) begin
                        cpu.mem_resp  = 1'b1;
                        cpu.mem_rdata = line_q[32*int'(offset) +: 32];
                        if (cpu.mem_write) begin
                            for (int b = 0; b < 4; b++) begin
                                if (cpu.mem_byte_enable[b])
                                    data_din[32*int'(offset) + 8*b +: 8] = cpu.mem_wdata[8*b +: 8];
                            end
                            data_ld   = 1'b1;
                            dirty_ld  = 1'b1;
                            dirty_din = 1'b1;
                        end
                    end else if (valid_q && dirty_q) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q, index, {S_OFFSET{1'b0}}};
                pmem_wdata   = line_q;
                if (pmem_resp) begin
                    dirty_ld   = 1'b1;
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {tag_in, index, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    data_ld    = 1'b1;
                    data_din   = pmem_rdata;
                    tag_ld     = 1'b1;
                    valid_ld   = 1'b1;
                    dirty_ld   = 1'b1;
                    state_next = CHECK;
                end
            end
            default: state_next = CHECK;
        endcase
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed CPU requests, a latency-3 line memory
// model, and monitors that check CPU responses and line transactions.
module tb_data_cache;
    import cache_types::*;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        int          issue;
        int          lat;
    } cpu_exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        line_t       data;
    } pmem_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pmem_read, pmem_write, pmem_resp;
    logic        resp_m, stray_m;
    logic [31:0] pmem_address;
    line_t       pmem_wdata, pmem_rdata;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    cpu_exp_t  sb_q[$];
    pmem_exp_t pm_q[$];
    line_t     pmem_mem [logic [31:0]];

    data_cache_if bus();

    assign pmem_resp = resp_m | stray_m;

    data_cache dut (
        .clk          (clk),
        .rst          (rst),
        .cpu          (bus),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fill pattern: byte i of the line is i, with bit 7 set when address bit 12 is set.
    function automatic line_t pat(input logic [31:0] a);
        line_t l;
        for (int i = 0; i < 32; i++) l[i*8 +: 8] = 8'(i) | (a[12] ? 8'h80 : 8'h00);
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input bit wr, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd, input bit chk, input logic [31:0] exp,
                          input int lat);
        int n;
        sb_q.push_back(cpu_exp_t'{chk, exp, cyc, lat});
        bus.mem_read        = !wr;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_address     = addr;
        bus.mem_wdata       = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_resp) break;
            n++;
            if (n > 100) begin
                check("req_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // CPU response monitor
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_resp) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_latency", 32'(cyc - e.issue), 32'(e.lat));
                    if (e.chk) check("rdata", bus.mem_rdata, e.exp);
                end
            end
        end
    end

    // Line memory model and transaction monitor
    initial begin
        int cnt = 0;
        pmem_exp_t e;
        resp_m     = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
            end else if (pmem_read || pmem_write) begin
                check("strobe_exclusive", 32'(pmem_read & pmem_write), 32'd0);
                cnt++;
                if (cnt == 1) begin
                    if (pm_q.size() == 0) begin
                        check("unexpected_pmem", pmem_address, 32'hFFFF_FFFF);
                    end else begin
                        e = pm_q.pop_front();
                        check("pmem_is_write", 32'(pmem_write), 32'(e.wr));
                        check("pmem_address", pmem_address, e.addr);
                        if (e.wr) begin
                            checks++;
                            if (pmem_wdata !== e.data) begin
                                fails++;
                                $display("FAIL pmem_wdata: got %h expected %h", pmem_wdata, e.data);
                            end
                        end
                    end
                end
                if (cnt == 3) begin
                    if (pmem_write) pmem_mem[pmem_address] = pmem_wdata;
                    else pmem_rdata = pmem_mem.exists(pmem_address) ? pmem_mem[pmem_address]
                                                                     : pat(pmem_address);
                    resp_m = 1'b1;
                    @(posedge clk); #1;
                    resp_m = 1'b0;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t mod_line;
        int n;
        rst                 = 1'b1;
        stray_m             = 1'b0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = '0;
        bus.mem_address     = '0;
        bus.mem_wdata       = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mem_resp", 32'(bus.mem_resp), 32'd0);
        check("rst_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_pmem_write", 32'(pmem_write), 32'd0);
        check("rst_pmem_address", pmem_address, 32'd0);
        @(posedge clk); #1;

        // cold read miss, hit, write hit, read-back
        pm_q.push_back(pmem_exp_t'{1'b0, 32'h0000_0100, '0});
        do_req(1'b0, 4'h0, 32'h0000_0104, 32'h0, 1'b1, 32'h0706_0504, 4);
        do_req(1'b0, 4'h0, 32'h0000_0108, 32'h0, 1'b1, 32'h0B0A_0908, 0);
        do_req(1'b1, 4'b0010, 32'h0000_0105, 32'h0000_AB00, 1'b0, 32'h0, 0);
        do_req(1'b0, 4'h0, 32'h0000_0104, 32'h0, 1'b1, 32'h0706_AB04, 0);

        // dirty eviction by a conflicting tag on set 0
        mod_line = pat(32'h0000_0100);
        mod_line[47:40] = 8'hAB;
        pm_q.push_back(pmem_exp_t'{1'b1, 32'h0000_0100, mod_line});
        pm_q.push_back(pmem_exp_t'{1'b0, 32'h0000_1100, '0});
        do_req(1'b0, 4'h0, 32'h0000_1104, 32'h0, 1'b1, 32'h8786_8584, 7);

        // clean miss back to the written-back line
        pm_q.push_back(pmem_exp_t'{1'b0, 32'h0000_0100, '0});
        do_req(1'b0, 4'h0, 32'h0000_0104, 32'h0, 1'b1, 32'h0706_AB04, 4);

        // reset while a fill is outstanding
        pm_q.push_back(pmem_exp_t'{1'b0, 32'h0000_0020, '0});
        bus.mem_read    = 1'b1;
        bus.mem_address = 32'h0000_0020;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pmem_read && n < 20);
        check("alloc_before_rst", 32'(pmem_read), 32'd1);
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_pmem_read", 32'(pmem_read), 32'd0);
        check("post_rst_pmem_write", 32'(pmem_write), 32'd0);
        @(posedge clk); #1;
        pm_q.push_back(pmem_exp_t'{1'b0, 32'h0000_0100, '0});
        do_req(1'b0, 4'h0, 32'h0000_0108, 32'h0, 1'b1, 32'h0B0A_0908, 4);

        // idle cycles and a stray line response while in CHECK
        repeat (3) begin
            @(negedge clk);
            check("idle_mem_resp", 32'(bus.mem_resp), 32'd0);
            check("idle_strobes", 32'({pmem_read, pmem_write}), 32'd0);
        end
        @(posedge clk); #1;
        stray_m = 1'b1;
        @(posedge clk); #1;
        stray_m = 1'b0;
        @(negedge clk);
        check("stray_strobes", 32'({pmem_read, pmem_write}), 32'd0);
        check("stray_mem_resp", 32'(bus.mem_resp), 32'd0);
        @(posedge clk); #1;
        do_req(1'b0, 4'h0, 32'h0000_0108, 32'h0, 1'b1, 32'h0B0A_0908, 0);
        do_req(1'b0, 4'h0, 32'h0000_0104, 32'h0, 1'b1, 32'h0706_AB04, 0);

        repeat (3) @(posedge clk);
        check("cpu_queue_drained", 32'(sb_q.size()), 32'd0);
        check("pmem_queue_drained", 32'(pm_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
